// File: rtl/eth_matrix_frame_rx.sv
// Ethernet-to-framebuffer writer for the LED matrix controller.
// Filters headers by destination MAC and ethertype, parses the matrix
// protocol payload (CMD, START, COUNT, pixels), issues framebuffer writes
// and buffer-swap pulses, and keeps saturating good/bad frame counters.
//
// Handshake semantics: a header transfers on a clock edge where
// s_eth_hdr_valid && s_eth_hdr_ready; a payload byte transfers on an edge
// where s_payload_tvalid && s_payload_tready. Ready never depends on valid.
module eth_matrix_frame_rx #(
    parameter logic [47:0] LOCAL_MAC       = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BCAST    = 1'b1,
    parameter logic [15:0] ETH_TYPE        = 16'h88B5,
    parameter int          MATRIX_W        = 64,
    parameter int          MATRIX_H        = 32,
    parameter int          BYTES_PER_PIXEL = 3,
    parameter int          ADDR_WIDTH      = $clog2(MATRIX_W * MATRIX_H),
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_eth_hdr_valid,
    output logic                         s_eth_hdr_ready,
    input  logic [47:0]                  s_eth_dest_mac,
    input  logic [15:0]                  s_eth_type,
    input  logic [7:0]                   s_payload_tdata,
    input  logic                         s_payload_tvalid,
    output logic                         s_payload_tready,
    input  logic                         s_payload_tlast,
    input  logic                         s_payload_tuser,
    output logic                         fb_wr_en,
    output logic [ADDR_WIDTH-1:0]        fb_wr_addr,
    output logic [8*BYTES_PER_PIXEL-1:0] fb_wr_data,
    output logic                         swap_req,
    output logic [CNT_WIDTH-1:0]         frames_ok,
    output logic [CNT_WIDTH-1:0]         frames_err,
    output logic [2:0]                   dbg_state
);

    localparam int PW   = 8 * BYTES_PER_PIXEL;
    localparam int NPIX = MATRIX_W * MATRIX_H;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_SWAIT = 3'd3,
        S_DROP  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    hdr_cnt;
    logic [7:0]    hdr_cmd;
    logic [15:0]   hdr_start;
    logic [7:0]    hdr_count_hi;
    logic [16:0]   cur_addr;     // one bit wider than START so it can sit at NPIX
    logic [15:0]   remain;
    logic [1:0]    byte_idx;
    logic [PW-1:0] pix_reg;

    logic          beat;
    logic          hdr_match;
    logic          hdr_last_byte;
    logic [15:0]   count_full;
    logic          pix_done;
    logic [PW-1:0] pix_next;
    logic          ok_inc;
    logic          err_inc;
    logic          swap_set;

    assign beat          = s_payload_tvalid && s_payload_tready;
    assign hdr_match     = ((s_eth_dest_mac == LOCAL_MAC) ||
                            (ACCEPT_BCAST && (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF))) &&
                           (s_eth_type == ETH_TYPE);
    assign hdr_last_byte = (hdr_cnt == 3'd4);
    assign count_full    = {hdr_count_hi, s_payload_tdata};
    assign pix_done      = (byte_idx == 2'(BYTES_PER_PIXEL - 1));
    assign pix_next      = PW'({pix_reg, s_payload_tdata});
    assign dbg_state     = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state, handshake readies and per-frame accounting events.
    always_comb begin
        state_nxt        = state;
        s_eth_hdr_ready  = 1'b0;
        s_payload_tready = 1'b0;
        ok_inc           = 1'b0;
        err_inc          = 1'b0;
        swap_set         = 1'b0;
        case (state)
            S_IDLE: begin
                s_eth_hdr_ready = 1'b1;
                if (s_eth_hdr_valid) state_nxt = hdr_match ? S_HDR : S_DROP;
            end
            S_HDR: begin
                s_payload_tready = 1'b1;
                if (beat) begin
                    if (s_payload_tlast) begin
                        state_nxt = S_IDLE;
                        // A swap command is complete once its 5 header bytes are in.
                        if (hdr_last_byte && hdr_cmd == 8'h02 && !s_payload_tuser) begin
                            ok_inc   = 1'b1;
                            swap_set = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (hdr_last_byte) begin
                        if (hdr_cmd == 8'h01 && count_full != 16'd0) begin
                            state_nxt = S_DATA;
                        end else if (hdr_cmd == 8'h02) begin
                            state_nxt = S_SWAIT;
                        end else begin
                            state_nxt = S_DROP;
                            err_inc   = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                s_payload_tready = 1'b1;
                if (beat && s_payload_tlast) begin
                    state_nxt = S_IDLE;
                    if (!s_payload_tuser &&
                        (remain == 16'd0 || (remain == 16'd1 && pix_done)))
                        ok_inc = 1'b1;
                    else
                        err_inc = 1'b1;
                end
            end
            S_SWAIT: begin
                s_payload_tready = 1'b1;
                if (beat && s_payload_tlast) begin
                    state_nxt = S_IDLE;
                    if (!s_payload_tuser) begin
                        ok_inc   = 1'b1;
                        swap_set = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            S_DROP: begin
                s_payload_tready = 1'b1;
                if (beat && s_payload_tlast) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Header capture, pixel assembly and registered framebuffer writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt      <= '0;
            hdr_cmd      <= '0;
            hdr_start    <= '0;
            hdr_count_hi <= '0;
            cur_addr     <= '0;
            remain       <= '0;
            byte_idx     <= '0;
            pix_reg      <= '0;
            fb_wr_en     <= 1'b0;
            fb_wr_addr   <= '0;
            fb_wr_data   <= '0;
        end else begin
            fb_wr_en <= 1'b0;
            if (state == S_IDLE) begin
                hdr_cnt <= '0;
            end else if (state == S_HDR && beat) begin
                hdr_cnt <= hdr_cnt + 3'd1;
                case (hdr_cnt)
                    3'd0:    hdr_cmd      <= s_payload_tdata;
                    3'd1:    hdr_start    <= {hdr_start[7:0], s_payload_tdata};
                    3'd2:    hdr_start    <= {hdr_start[7:0], s_payload_tdata};
                    3'd3:    hdr_count_hi <= s_payload_tdata;
                    default: begin
                        cur_addr <= {1'b0, hdr_start};
                        remain   <= count_full;
                        byte_idx <= '0;
                        pix_reg  <= '0;
                    end
                endcase
            end else if (state == S_DATA && beat) begin
                pix_reg <= pix_next;
                if (pix_done) begin
                    byte_idx <= '0;
                    // Pixels past COUNT are padding; addresses past the end are skipped.
                    if (remain != 16'd0) begin
                        remain <= remain - 16'd1;
                        if (cur_addr < 17'(NPIX)) begin
                            fb_wr_en   <= 1'b1;
                            fb_wr_addr <= cur_addr[ADDR_WIDTH-1:0];
                            fb_wr_data <= pix_next;
                            cur_addr   <= cur_addr + 17'd1;
                        end
                    end
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    // Swap pulse and saturating frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_req   <= 1'b0;
            frames_ok  <= '0;
            frames_err <= '0;
        end else begin
            swap_req <= swap_set;
            if (ok_inc && frames_ok != '1)   frames_ok  <= frames_ok + 1'b1;
            if (err_inc && frames_err != '1) frames_err <= frames_err + 1'b1;
        end
    end

endmodule
